// File: rtl/gol_gen_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : gol_gen_scheduler_if
// Brief    : Control, display, engine and board-memory port bundle for the
//            Game of Life generation scheduler.
// Revision : 1.0
// ============================================================================
interface gol_gen_scheduler_if #(
    parameter int ADDR_W = 11
);
    logic              run;
    logic              randomize_en;
    logic              frame_tick;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              init_req,   upd_req,   cpy_req;
    logic [ADDR_W-1:0] init_addr,  upd_addr,  cpy_addr;
    logic              init_we,    upd_we,    cpy_we;
    logic              init_wdata, upd_wdata, cpy_wdata;
    logic              init_done,  upd_done,  cpy_done;
    logic              init_start, upd_start, cpy_start;
    logic              init_gnt,   upd_gnt,   cpy_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_wdata;
    logic              busy;
    logic [15:0]       gen_count;

    modport master (
        output run, randomize_en, frame_tick, disp_req, disp_addr,
               init_req, upd_req, cpy_req, init_addr, upd_addr, cpy_addr,
               init_we, upd_we, cpy_we, init_wdata, upd_wdata, cpy_wdata,
               init_done, upd_done, cpy_done,
        input  init_start, upd_start, cpy_start, init_gnt, upd_gnt, cpy_gnt,
               mem_addr, mem_we, mem_wdata, busy, gen_count
    );

    modport slave (
        input  run, randomize_en, frame_tick, disp_req, disp_addr,
               init_req, upd_req, cpy_req, init_addr, upd_addr, cpy_addr,
               init_we, upd_we, cpy_we, init_wdata, upd_wdata, cpy_wdata,
               init_done, upd_done, cpy_done,
        output init_start, upd_start, cpy_start, init_gnt, upd_gnt, cpy_gnt,
               mem_addr, mem_we, mem_wdata, busy, gen_count
    );
endinterface
`default_nettype wire

// File: rtl/gol_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gol_gen_scheduler
// Brief    : Steps init/update/copy engines per generation and arbitrates the
//            single board-memory port (display scanout has priority).
// Revision : 1.0
// ============================================================================
module gol_gen_scheduler #(
    parameter int ADDR_W          = 11,
    parameter int TIMER_W         = 22,
    parameter int UPDATE_INTERVAL = 2400000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    gol_gen_scheduler_if.slave bus
);

    localparam logic [TIMER_W-1:0] INTERVAL = TIMER_W'(UPDATE_INTERVAL);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_INIT   = 3'd1,
        ST_UPDATE = 3'd2,
        ST_COPY   = 3'd3,
        ST_IDLE   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic               trigger;
    logic               init_start_next;
    logic               upd_start_next;
    logic               cpy_start_next;
    logic               active_req;
    logic [ADDR_W-1:0]  active_addr;
    logic               active_we;
    logic               active_wdata;
    logic               active_gnt;

    // Registered timer is compared, so a tick on the edge it saturates misses.
    assign trigger = (state == ST_IDLE) && bus.run && (timer == INTERVAL) && bus.frame_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_BOOT;
            timer          <= '0;
            bus.gen_count  <= 16'd0;
            bus.init_start <= 1'b0;
            bus.upd_start  <= 1'b0;
            bus.cpy_start  <= 1'b0;
        end else begin
            state          <= state_next;
            bus.init_start <= init_start_next;
            bus.upd_start  <= upd_start_next;
            bus.cpy_start  <= cpy_start_next;
            if (state == ST_IDLE) begin
                if (trigger)
                    timer <= '0;
                else if (bus.run && (timer < INTERVAL))
                    timer <= timer + TIMER_W'(1);
            end
            if ((state == ST_COPY) && bus.cpy_done)
                bus.gen_count <= bus.gen_count + 16'd1;
        end
    end

    always_comb begin
        state_next      = state;
        init_start_next = 1'b0;
        upd_start_next  = 1'b0;
        cpy_start_next  = 1'b0;
        case (state)
            ST_BOOT: begin
                state_next      = ST_INIT;
                init_start_next = 1'b1;
            end
            ST_INIT: begin
                if (bus.init_done)
                    state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (trigger) begin
                    if (bus.randomize_en) begin
                        state_next      = ST_INIT;
                        init_start_next = 1'b1;
                    end else begin
                        state_next     = ST_UPDATE;
                        upd_start_next = 1'b1;
                    end
                end
            end
            ST_UPDATE: begin
                if (bus.upd_done) begin
                    state_next     = ST_COPY;
                    cpy_start_next = 1'b1;
                end
            end
            ST_COPY: begin
                if (bus.cpy_done)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        active_req   = 1'b0;
        active_addr  = '0;
        active_we    = 1'b0;
        active_wdata = 1'b0;
        case (state)
            ST_INIT: begin
                active_req   = bus.init_req;
                active_addr  = bus.init_addr;
                active_we    = bus.init_we;
                active_wdata = bus.init_wdata;
            end
            ST_UPDATE: begin
                active_req   = bus.upd_req;
                active_addr  = bus.upd_addr;
                active_we    = bus.upd_we;
                active_wdata = bus.upd_wdata;
            end
            ST_COPY: begin
                active_req   = bus.cpy_req;
                active_addr  = bus.cpy_addr;
                active_we    = bus.cpy_we;
                active_wdata = bus.cpy_wdata;
            end
            default: ;
        endcase
    end

    assign active_gnt    = active_req & ~bus.disp_req;
    assign bus.init_gnt  = (state == ST_INIT)   & active_gnt;
    assign bus.upd_gnt   = (state == ST_UPDATE) & active_gnt;
    assign bus.cpy_gnt   = (state == ST_COPY)   & active_gnt;
    assign bus.mem_addr  = bus.disp_req ? bus.disp_addr : active_addr;
    assign bus.mem_we    = active_gnt & active_we;
    assign bus.mem_wdata = active_gnt & active_wdata;
    assign bus.busy      = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gol_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gol_gen_scheduler
// Brief    : Random stimulus with a generation-level reference model feeding
//            an expected-output queue drained by a mid-cycle monitor.
// Revision : 1.0
// ============================================================================
module tb_gol_gen_scheduler;

    localparam int INTERVAL = 4;
    localparam int NCYC     = 4000;

    localparam int M_BOOT   = 0;
    localparam int M_INIT   = 1;
    localparam int M_UPDATE = 2;
    localparam int M_COPY   = 3;
    localparam int M_IDLE   = 4;

    typedef struct {
        logic        istart, ustart, cstart;
        logic        ig, ug, cg;
        logic [10:0] addr;
        logic        we, wd, busy;
        logic [15:0] gen;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    exp_t q[$];

    int          m_mode;
    int          m_timer;
    int          m_gen;
    logic [2:0]  m_start;

    gol_gen_scheduler_if #(.ADDR_W(11)) bus ();

    gol_gen_scheduler #(
        .ADDR_W(11),
        .TIMER_W(22),
        .UPDATE_INTERVAL(INTERVAL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: outputs are sampled mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("init_start", 32'(bus.init_start), 32'(e.istart));
                chk("upd_start",  32'(bus.upd_start),  32'(e.ustart));
                chk("cpy_start",  32'(bus.cpy_start),  32'(e.cstart));
                chk("init_gnt",   32'(bus.init_gnt),   32'(e.ig));
                chk("upd_gnt",    32'(bus.upd_gnt),    32'(e.ug));
                chk("cpy_gnt",    32'(bus.cpy_gnt),    32'(e.cg));
                chk("mem_addr",   32'(bus.mem_addr),   32'(e.addr));
                chk("mem_we",     32'(bus.mem_we),     32'(e.we));
                chk("mem_wdata",  32'(bus.mem_wdata),  32'(e.wd));
                chk("busy",       32'(bus.busy),       32'(e.busy));
                chk("gen_count",  32'(bus.gen_count),  32'(e.gen));
            end
        end
    end

    task automatic model_reset();
        m_mode  = M_BOOT;
        m_timer = 0;
        m_gen   = 0;
        m_start = 3'b000;
    endtask

    task automatic drive_random();
        bus.run          = ($urandom_range(0, 9) != 0);
        bus.randomize_en = ($urandom_range(0, 3) == 0);
        bus.frame_tick   = ($urandom_range(0, 3) == 0);
        bus.disp_req     = $urandom_range(0, 1) == 1;
        bus.disp_addr    = 11'($urandom);
        bus.init_req     = $urandom_range(0, 1) == 1;
        bus.upd_req      = $urandom_range(0, 1) == 1;
        bus.cpy_req      = $urandom_range(0, 1) == 1;
        bus.init_addr    = 11'($urandom);
        bus.upd_addr     = 11'($urandom);
        bus.cpy_addr     = 11'($urandom);
        bus.init_we      = $urandom_range(0, 1) == 1;
        bus.upd_we       = $urandom_range(0, 1) == 1;
        bus.cpy_we       = $urandom_range(0, 1) == 1;
        bus.init_wdata   = $urandom_range(0, 1) == 1;
        bus.upd_wdata    = $urandom_range(0, 1) == 1;
        bus.cpy_wdata    = $urandom_range(0, 1) == 1;
        bus.init_done    = ($urandom_range(0, 5) == 0);
        bus.upd_done     = ($urandom_range(0, 5) == 0);
        bus.cpy_done     = ($urandom_range(0, 5) == 0);
    endtask

    function automatic exp_t model_outputs();
        exp_t        e;
        int          eng;
        logic [2:0]  req, we, wd, done_unused;
        logic [10:0] addr [3];
        req  = {bus.cpy_req,   bus.upd_req,   bus.init_req};
        we   = {bus.cpy_we,    bus.upd_we,    bus.init_we};
        wd   = {bus.cpy_wdata, bus.upd_wdata, bus.init_wdata};
        addr[0] = bus.init_addr;
        addr[1] = bus.upd_addr;
        addr[2] = bus.cpy_addr;
        done_unused = 3'b000;
        eng = (m_mode == M_INIT) ? 0 : (m_mode == M_UPDATE) ? 1 : (m_mode == M_COPY) ? 2 : -1;
        e.istart = m_start[0];
        e.ustart = m_start[1];
        e.cstart = m_start[2];
        e.ig = 1'b0; e.ug = 1'b0; e.cg = 1'b0;
        e.we = 1'b0; e.wd = 1'b0;
        e.addr = 11'd0;
        if (eng >= 0) begin
            e.addr = addr[eng];
            if (req[eng] && !bus.disp_req) begin
                if (eng == 0) e.ig = 1'b1;
                if (eng == 1) e.ug = 1'b1;
                if (eng == 2) e.cg = 1'b1;
                e.we = we[eng];
                e.wd = wd[eng];
            end
        end
        if (bus.disp_req) e.addr = bus.disp_addr;
        e.busy = (m_mode != M_IDLE);
        e.gen  = 16'(m_gen);
        return e;
    endfunction

    task automatic model_step();
        m_start = 3'b000;
        if (m_mode == M_BOOT) begin
            m_mode = M_INIT; m_start[0] = 1'b1;
        end else if (m_mode == M_INIT) begin
            if (bus.init_done) m_mode = M_IDLE;
        end else if (m_mode == M_UPDATE) begin
            if (bus.upd_done) begin m_mode = M_COPY; m_start[2] = 1'b1; end
        end else if (m_mode == M_COPY) begin
            if (bus.cpy_done) begin m_mode = M_IDLE; m_gen = (m_gen + 1) % 65536; end
        end else begin
            if (bus.run && m_timer == INTERVAL && bus.frame_tick) begin
                m_timer = 0;
                if (bus.randomize_en) begin m_mode = M_INIT;   m_start[0] = 1'b1; end
                else                  begin m_mode = M_UPDATE; m_start[1] = 1'b1; end
            end else if (bus.run && m_timer < INTERVAL) begin
                m_timer = m_timer + 1;
            end
        end
    endtask

    initial begin
        int rst_hold;
        bit copy_reset_done;
        rst_hold = 0;
        copy_reset_done = 0;
        reset = 1'b1;
        drive_random();
        model_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            drive_random();
            if (cyc < 3) begin
                reset = 1'b1;
            end else if (rst_hold > 0) begin
                rst_hold--;
                reset = 1'b1;
            end else if ((!copy_reset_done && cyc > 1500 && m_mode == M_COPY) ||
                         ($urandom_range(0, 299) == 0)) begin
                copy_reset_done = 1;
                rst_hold = $urandom_range(0, 2);
                reset = 1'b1;
            end else begin
                reset = 1'b0;
            end
            if (reset) model_reset();
            q.push_back(model_outputs());
            if (!reset) model_step();
        end
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
